// File: rtl/dmem_resp_if.sv
// Request/response bus between a core and the dmem_resp data memory.
// The master modport is the core side and the slave modport is the memory side.
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic        req_uext;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_width, req_uext, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_width, req_uext, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// Single-request data memory with fixed access latency and byte/half/word lanes.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses instead of aligning them down.
module dmem_resp #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_resp_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  logic                we_q, uext_q;
  logic [1:0]          width_q;
  logic [IDX_W+1:0]    addr_q;
  logic [31:0]         wdata_q;

  logic [31:0]         mem_q [DEPTH];

  logic                latch_en_c, mem_we_c, err_c;
  logic [IDX_W-1:0]    idx_c;
  logic [1:0]          off_c;
  logic [3:0]          be_c;
  logic [31:0]         wlane_c, word_c, shf_c, load_c;
  logic                unused_addr;

  assign unused_addr = ^bus.req_addr[31:IDX_W+2];

  // Request capture; only the bits that select a word and a lane are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uext_q  <= 1'b0;
      width_q <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch_en_c) begin
      we_q    <= bus.req_we;
      uext_q  <= bus.req_uext;
      width_q <= bus.req_width;
      addr_q  <= bus.req_addr[IDX_W+1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  // Access decode: error, lane offset, byte enables and load extraction.
  always_comb begin
    idx_c   = addr_q[IDX_W+1:2];
    err_c   = (width_q == 2'b11);
`ifdef DMEM_MISALIGN_ERR_EN
    err_c   = err_c || ((width_q == 2'b01) && addr_q[0])
                    || ((width_q == 2'b10) && (addr_q[1:0] != 2'b00));
`endif
    off_c   = 2'b00;
    be_c    = 4'b1111;
    wlane_c = wdata_q;
    case (width_q)
      2'b00: begin
        off_c   = addr_q[1:0];
        be_c    = 4'(4'b0001 << off_c);
        wlane_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        off_c   = {addr_q[1], 1'b0};
        be_c    = 4'(4'b0011 << off_c);
        wlane_c = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
    word_c = mem_q[idx_c];
    shf_c  = word_c >> {off_c, 3'b000};
    case (width_q)
      2'b00:   load_c = uext_q ? {24'h0, shf_c[7:0]}  : {{24{shf_c[7]}}, shf_c[7:0]};
      2'b01:   load_c = uext_q ? {16'h0, shf_c[15:0]} : {{16{shf_c[15]}}, shf_c[15:0]};
      default: load_c = word_c;
    endcase
  end

  // Array has no reset; writes only happen from WAIT, which reset leaves.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_c && be_c[i]) begin
        mem_q[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    latch_en_c   = 1'b0;
    mem_we_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          latch_en_c = 1'b1;
          cnt_d      = CNT_W'(LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          mem_we_c     = we_q && !err_c;
          resp_valid_d = 1'b1;
          resp_err_d   = err_c;
          resp_rdata_d = (we_q || err_c) ? 32'h0 : load_c;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Drives identical request streams into a LATENCY=1 and a LATENCY=3 instance and
// compares both against a byte-addressed reference memory.
module tb_dmem_resp;

  localparam int DEPTH = 1024;
  localparam int NB    = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_resp_if if1 ();
  dmem_resp_if if3 ();

  dmem_resp #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  dmem_resp #(.DEPTH(DEPTH), .LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  int checks = 0;
  int errors = 0;
  logic [7:0] mb [NB];
  int lat_of [2] = '{1, 3};

  logic        v  [2];
  logic        rr [2];
  logic        er [2];
  logic [31:0] rd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    v[0] = if1.resp_valid; rr[0] = if1.req_ready; er[0] = if1.resp_err; rd[0] = if1.resp_rdata;
    v[1] = if3.resp_valid; rr[1] = if3.req_ready; er[1] = if3.resp_err; rd[1] = if3.resp_rdata;
  endtask

  task automatic drive(input logic vld, input logic we, input logic [31:0] a,
                       input logic [1:0] w, input logic u, input logic [31:0] wd);
    if1.req_valid = vld; if1.req_we = we; if1.req_addr = a;
    if1.req_width = w;   if1.req_uext = u; if1.req_wdata = wd;
    if3.req_valid = vld; if3.req_we = we; if3.req_addr = a;
    if3.req_width = w;   if3.req_uext = u; if3.req_wdata = wd;
  endtask

  task automatic set_ready(input logic r);
    if1.resp_ready = r;
    if3.resp_ready = r;
  endtask

  // Reference: byte array, alignment and extension from plain arithmetic.
  task automatic model(input logic we, input logic [31:0] a, input logic [1:0] w,
                       input logic u, input logic [31:0] wd,
                       output logic err, output logic [31:0] rdata);
    int n, ba, base;
    logic [31:0] val;
    n  = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    ba = int'(a % NB);
    err = (w == 2'd3);
`ifdef DMEM_MISALIGN_ERR_EN
    if (w != 2'd3 && (ba % n) != 0) err = 1'b1;
`endif
    base  = ba - (ba % n);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < n; i++) val = val | (32'(mb[base + i]) << (8 * i));
        if (n < 4 && !u && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
        rdata = val;
      end
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [1:0] w,
                     input logic u, input logic [31:0] wd, input int stall);
    logic        e_err;
    logic [31:0] e_rd;
    bit          seen [2];
    bit          done [2];
    logic        rdy;
    int          n;
    model(we, a, w, u, wd, e_err, e_rd);
    sample();
    check("req_ready_idle_l1", 32'(rr[0]), 32'h1);
    check("req_ready_idle_l3", 32'(rr[1]), 32'h1);
    drive(1'b1, we, a, w, u, wd);
    set_ready(1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    seen = '{0, 0};
    done = '{0, 0};
    n = 0;
    sample();
    while (!(done[0] && done[1]) && n < 64) begin
      rdy = (n >= stall);
      set_ready(rdy);
      // A store request while both blocks are busy must be ignored.
      if (!rr[0] && !rr[1] && n[0])
        drive(1'b1, 1'b1, $urandom & 32'h0000_007C, 2'd2, 1'b0, $urandom);
      else
        drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
      @(posedge clk); #1;
      n++;
      sample();
      for (int k = 0; k < 2; k++) begin
        if (done[k]) continue;
        if (!seen[k]) begin
          if (v[k]) begin
            seen[k] = 1;
            check($sformatf("latency_d%0d", k), 32'(n), 32'(lat_of[k]));
            check($sformatf("rdata_d%0d_a%h", k, a), rd[k], e_rd);
            check($sformatf("err_d%0d_a%h", k, a), 32'(er[k]), 32'(e_err));
            check($sformatf("req_ready_resp_d%0d", k), 32'(rr[k]), 32'h0);
          end else begin
            check($sformatf("wait_state_d%0d", k), {30'h0, rr[k], er[k]}, 32'h0);
          end
        end else if (rdy) begin
          check($sformatf("after_hs_d%0d", k), {29'h0, v[k], rr[k], er[k]}, 32'h2);
          done[k] = 1;
        end else begin
          check($sformatf("hold_valid_d%0d", k), 32'(v[k]), 32'h1);
          check($sformatf("hold_rdata_d%0d", k), rd[k], e_rd);
          check($sformatf("hold_err_d%0d", k), 32'(er[k]), 32'(e_err));
          check($sformatf("hold_ready_d%0d", k), 32'(rr[k]), 32'h0);
        end
      end
    end
    check("txn_complete", {30'h0, 1'(done[0]), 1'(done[1])}, 32'h3);
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    set_ready(1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    sample();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_d%0d", tag, k), {29'h0, v[k], rr[k], er[k]}, 32'h2);
      check($sformatf("%s_rdata_d%0d", tag, k), rd[k], 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  w;
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    set_ready(1'b0);
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic word store and load.
    txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);

    // Sign/zero extension of byte and half loads.
    txn(1'b1, 32'h20, 2'd2, 1'b0, 32'h80F1_7F02, 0);
    txn(1'b0, 32'h23, 2'd0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h23, 2'd0, 1'b1, 32'h0, 0);
    txn(1'b0, 32'h20, 2'd1, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, 0);

    // Byte-lane store merge.
    txn(1'b1, 32'h20, 2'd2, 1'b0, 32'h1122_3344, 0);
    txn(1'b1, 32'h21, 2'd0, 1'b0, 32'hFFFF_FFAA, 0);
    txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0);

    // Response held off by the core.
    txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 5);

    // Misaligned word and half; address wrap through high bits.
    txn(1'b0, 32'h22, 2'd2, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h21, 2'd1, 1'b1, 32'h0, 1);
    txn(1'b0, 32'hABC0_0020, 2'd2, 1'b0, 32'h0, 0);

    // Reset during WAIT aborts the store.
    txn(1'b1, 32'h40, 2'd2, 1'b0, 32'h5566_7788, 0);
    drive(1'b1, 1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFE_F00D);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) begin
      @(posedge clk); #1;
      check_reset_outputs("in_reset");
    end
    rst_n = 1'b1;
    txn(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0);

    // Illegal width leaves the array untouched.
    txn(1'b1, 32'h40, 2'd3, 1'b0, 32'h0BAD_0BAD, 0);
    txn(1'b0, 32'h40, 2'd3, 1'b1, 32'h0, 0);
    txn(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 0);

    // Randomised traffic over a pre-initialised window.
    for (int i = 0; i < 32; i++) txn(1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom, 0);
    for (int i = 0; i < 80; i++) begin
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      w  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wd = $urandom;
      txn(1'($urandom_range(0, 1)), a, w, 1'($urandom_range(0, 1)), wd, $urandom_range(0, 3));
    end
    for (int i = 0; i < 32; i++) txn(1'b0, 32'(4 * i), 2'd2, 1'b0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 1024, is the number of 32-bit words in the array and SHALL be a power of two.
REQ-002 Parameter LATENCY, default 1, is the number of cycles from request accept to response and SHALL be at least 1.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port req_valid, input, 1 bit: the core presents a request.
REQ-006 Port req_ready, output, 1 bit: the block can accept a request.
REQ-007 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 Port req_addr, input, 32 bits: byte address.
REQ-009 Port req_width, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 Port req_uext, input, 1 bit: on loads, 1 = zero-extend and 0 = sign-extend.
REQ-011 Port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 Port resp_valid, output, 1 bit: response available.
REQ-013 Port resp_ready, input, 1 bit: the core accepts the response.
REQ-014 Port resp_rdata, output, 32 bits: load result after extension.
REQ-015 Port resp_err, output, 1 bit: the request was rejected.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, a cycle with req_valid=1 is an accept: the block SHALL latch we, addr, width, uext and wdata, load a counter with LATENCY-1, and go to WAIT.
REQ-018 In WAIT, the block SHALL decrement the counter each cycle and, on the edge where the counter is 0, perform the access, register the results, and go to RESP.
  - resp_valid therefore rises exactly LATENCY cycles after the accepting edge.
REQ-019 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-020 A store SHALL update only the addressed lanes:
  - byte: lane addr[1:0] gets wdata[7:0];
  - half: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0];
  - word: all four lanes.
REQ-021 For a store, resp_rdata SHALL be 0.
REQ-022 A load SHALL extract the addressed byte, half or word, then extend it to 32 bits with zeros if uext=1 or with its MSB if uext=0; uext SHALL be ignored for word loads.
REQ-023 width=11 SHALL set resp_err=1, suppress the write, and drive resp_rdata=0.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_valid=1 and resp_ready=1 on the same cycle; the FSM then goes to IDLE.
REQ-025 Requests SHALL NOT be pipelined: the minimum accept-to-accept spacing is LATENCY+2 cycles, and req_valid outside IDLE SHALL be ignored.
REQ-026 resp_valid and resp_err SHALL be 0 outside RESP.

Reset
REQ-027 When rst_n=0, the block SHALL enter IDLE immediately, with resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 and counter=0.
REQ-028 Reset during WAIT or RESP SHALL abort the transaction with no array write; array contents SHALL NOT be cleared by reset and are undefined at power-up.
REQ-029 After rst_n deasserts, a request SHALL be acceptable on the first rising edge.

Configuration
REQ-030 Macro DMEM_MISALIGN_ERR_EN controls misaligned-access handling.
  - Defined: a half with addr[0]=1, or a word with addr[1:0]!=00, SHALL give resp_err=1, no write and resp_rdata=0.
  - Undefined: a half SHALL ignore addr[0], a word SHALL ignore addr[1:0], and resp_err SHALL be raised only for width=11.

Verification
REQ-031 LATENCY=1: store word 0xDEADBEEF to 0x10, then load word from 0x10 -> each resp_valid 1 cycle after its accept; load returns rdata=0xDEADBEEF, err=0.
REQ-032 Word 0x80F1_7F02 at 0x20; load byte 0x23 with uext=0 -> 0xFFFFFF80; uext=1 -> 0x00000080; load half 0x20 with uext=0 -> 0x00007F02.
REQ-033 Store byte 0xAA to 0x21 over word 0x11223344 at 0x20, then load word 0x20 -> 0x1122AA44.
REQ-034 LATENCY=3, resp_ready held 0 for 5 cycles -> resp_valid high from accept+3 until the handshake, rdata stable throughout, req_ready=0 throughout.
REQ-035 Load word at 0x22 -> with DMEM_MISALIGN_ERR_EN, err=1 and rdata=0; without it, err=0 and rdata equals the word at 0x20.
REQ-036 Assert rst_n=0 during WAIT of a store to 0x40 -> resp_valid never asserts, and a later load of 0x40 returns the prior value; width=11 request -> err=1 with the array unchanged.
